// File: rtl/commbridge_ahb2apb.sv
// commbridge_ahb2apb: single-clock AHB-Lite slave to APB master bridge.
//
// Each accepted AHB transfer is turned into one APB setup/access sequence.
// Read data, wait states and slave errors go back to the AHB master. Errors
// use the usual two-cycle AHB response (ERR1 low-ready, ERR2 ready).
//
// Optional feature macro: COMMBRIDGE_APB4_EN (adds PSTRB, PPROT and HPROT).
//
// Ports:
//   PCLK, PRESETn          clock, asynchronous active-low reset
//   HSEL, HADDR, HTRANS,   AHB address phase (HSIZE only used with APB4)
//   HSIZE, HWRITE, HREADY
//   HWDATA                 AHB write data (data phase)
//   HREADYOUT, HRDATA,     AHB slave response
//   HRESP
//   PSEL, PADDR, PENABLE,  APB master request
//   PWRITE, PWDATA
//   PRDATA, PREADY,        APB slave response
//   PSLVERR
//   PSTRB, PPROT, HPROT    APB4 extensions (only with the macro)
//   fsm_state              current FSM state, for debug and checkers
//
// Handshake: an AHB transfer is taken when HSEL & HTRANS[1] & HREADY is high
// at a rising edge while the bridge is ready (IDLE, DONE or ERR2). An APB
// transfer completes on the rising edge where PSEL & PENABLE & PREADY.
module commbridge_ahb2apb #(
    parameter int ADDRWIDTH = 12
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    input  logic                 HSEL,
    input  logic [ADDRWIDTH-1:0] HADDR,
    input  logic [1:0]           HTRANS,
    input  logic [2:0]           HSIZE,
    input  logic                 HWRITE,
    input  logic                 HREADY,
    input  logic [31:0]          HWDATA,
    output logic                 HREADYOUT,
    output logic [31:0]          HRDATA,
    output logic                 HRESP,
    output logic                 PSEL,
    output logic [ADDRWIDTH-3:0] PADDR,
    output logic                 PENABLE,
    output logic                 PWRITE,
    output logic [31:0]          PWDATA,
    input  logic [31:0]          PRDATA,
    input  logic                 PREADY,
    input  logic                 PSLVERR,
`ifdef COMMBRIDGE_APB4_EN
    output logic [3:0]           PSTRB,
    output logic [2:0]           PPROT,
    input  logic [3:0]           HPROT,
`endif
    output logic [2:0]           fsm_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_ACCESS = 3'd2,
        S_DONE   = 3'd3,
        S_ERR1   = 3'd4,
        S_ERR2   = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDRWIDTH-3:0]   paddr_q;
    logic                   pwrite_q;
    logic [31:0]            pwdata_q;
    logic [31:0]            hrdata_q;
    logic                   ready_state;
    logic                   accept;

    // Only states that drive HREADYOUT=1 can take a new address phase.
    assign ready_state = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR2);
    assign accept      = HSEL && HTRANS[1] && HREADY && ready_state;

`ifdef COMMBRIDGE_APB4_EN
    logic [3:0] pstrb_q, pstrb_d;
    logic [2:0] pprot_q;
    logic       unused_bits;

    always_comb begin
        pstrb_d = 4'b0000;
        if (HWRITE) begin
            case (HSIZE)
                3'd0:    pstrb_d = 4'b0001 << HADDR[1:0];
                3'd1:    pstrb_d = 4'b0011 << {HADDR[1], 1'b0};
                default: pstrb_d = 4'b1111;
            endcase
        end
    end

    assign PSTRB       = pstrb_q;
    assign PPROT       = pprot_q;
    assign unused_bits = ^{HTRANS[0], HPROT[3:2]};
`else
    logic unused_bits;
    assign unused_bits = ^{HSIZE, HADDR[1:0], HTRANS[0]};
`endif

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q  <= S_IDLE;
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            hrdata_q <= '0;
`ifdef COMMBRIDGE_APB4_EN
            pstrb_q  <= 4'b0000;
            pprot_q  <= 3'b000;
`endif
        end else begin
            state_q <= state_d;
            if (accept) begin
                paddr_q  <= HADDR[ADDRWIDTH-1:2];
                pwrite_q <= HWRITE;
`ifdef COMMBRIDGE_APB4_EN
                pstrb_q  <= pstrb_d;
                pprot_q  <= {~HPROT[0], 1'b0, HPROT[1]};
`endif
            end
            // HWDATA is only valid in the first data-phase cycle; hold it
            // for the access phase and beyond.
            if (state_q == S_SETUP) begin
                pwdata_q <= HWDATA;
            end
            if ((state_q == S_ACCESS) && PREADY && !PSLVERR && !pwrite_q) begin
                hrdata_q <= PRDATA;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (accept) state_d = S_SETUP;
            S_SETUP:  state_d = S_ACCESS;
            S_ACCESS: if (PREADY) state_d = PSLVERR ? S_ERR1 : S_DONE;
            S_DONE:   state_d = accept ? S_SETUP : S_IDLE;
            S_ERR1:   state_d = S_ERR2;
            S_ERR2:   state_d = accept ? S_SETUP : S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the state register alone so an asynchronous
    // reset returns them to their idle values immediately.
    always_comb begin
        HREADYOUT = ready_state;
        HRESP     = (state_q == S_ERR1) || (state_q == S_ERR2);
        PSEL      = (state_q == S_SETUP) || (state_q == S_ACCESS);
        PENABLE   = (state_q == S_ACCESS);
        PWDATA    = (state_q == S_SETUP) ? HWDATA : pwdata_q;
    end

    assign HRDATA    = hrdata_q;
    assign PADDR     = paddr_q;
    assign PWRITE    = pwrite_q;
    assign fsm_state = state_q;

endmodule

// File: tb/tb_commbridge_ahb2apb.sv
module tb_commbridge_ahb2apb;
  localparam int AW = 12;

  logic          PCLK = 1'b0;
  logic          PRESETn = 1'b0;
  logic          HSEL = 1'b0;
  logic [AW-1:0] HADDR = '0;
  logic [1:0]    HTRANS = 2'b00;
  logic [2:0]    HSIZE = 3'd2;
  logic          HWRITE = 1'b0;
  logic          HREADY;
  logic [31:0]   HWDATA = '0;
  logic          HREADYOUT;
  logic [31:0]   HRDATA;
  logic          HRESP;
  logic          PSEL;
  logic [AW-3:0] PADDR;
  logic          PENABLE;
  logic          PWRITE;
  logic [31:0]   PWDATA;
  logic [31:0]   PRDATA = '0;
  logic          PREADY = 1'b0;
  logic          PSLVERR = 1'b0;
  logic [2:0]    fsm_state;
`ifdef COMMBRIDGE_APB4_EN
  logic [3:0]    PSTRB;
  logic [2:0]    PPROT;
  logic [3:0]    HPROT = '0;
`endif

  // single-slave bus: HREADY follows the bridge's own HREADYOUT
  assign HREADY = HREADYOUT;

  commbridge_ahb2apb #(.ADDRWIDTH(AW)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HWRITE(HWRITE), .HREADY(HREADY), .HWDATA(HWDATA),
    .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .HRESP(HRESP), .PSEL(PSEL),
    .PADDR(PADDR), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
`ifdef COMMBRIDGE_APB4_EN
    .PSTRB(PSTRB), .PPROT(PPROT), .HPROT(HPROT),
`endif
    .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 PCLK = ~PCLK;

  initial begin
    #400000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic [AW-3:0] paddr;
    logic          pwrite;
    logic [31:0]   pwdata;
    logic [3:0]    pstrb;
    logic [2:0]    pprot;
  } apb_t;

  typedef struct packed {
    logic [31:0] hrdata;
    logic        err;
    logic [7:0]  waits;
  } ahb_t;

  typedef struct packed {
    logic [7:0]  waits;
    logic        err;
    logic [31:0] rdata;
  } slv_t;

  apb_t apb_q[$];
  ahb_t ahb_q[$];
  slv_t slv_q[$];

  logic [31:0] model_hrdata = '0;
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // All drivers change inputs 1 time unit after the rising edge.
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      HSEL   = 1'($urandom_range(0, 1));
      HTRANS = 2'($urandom_range(0, 1));  // IDLE or BUSY: never accepted
      HADDR  = AW'($urandom);
      @(posedge PCLK); #1;
    end
    HSEL   = 1'b0;
    HTRANS = 2'b00;
  endtask

  task automatic wait_ready(input string name);
    int guard;
    guard = 0;
    while (HREADYOUT !== 1'b1 && guard < 60) begin
      @(posedge PCLK); #1;
      guard++;
    end
    if (guard >= 60) check(name, 32'(HREADYOUT), 32'd1);
  endtask

  // Issue one transfer; returns in the completion cycle so a following call
  // drives its address phase back-to-back.
  task automatic issue(input logic [AW-1:0] addr, input logic wr, input logic [2:0] size,
                       input logic [31:0] wdata, input int w, input logic err,
                       input logic [31:0] rdata);
    apb_t a;
    ahb_t h;
    slv_t s;
    logic [3:0] prot;
    int sh;
    wait_ready("issue_ready_timeout");
    prot = 4'($urandom_range(0, 15));
    a.paddr  = addr[AW-1:2];
    a.pwrite = wr;
    a.pwdata = wdata;
    sh = int'(addr[1:0]);
    if (!wr)            a.pstrb = 4'd0;
    else if (size == 0) a.pstrb = 4'(1 << sh);
    else if (size == 1) a.pstrb = 4'(3 << ((sh / 2) * 2));
    else                a.pstrb = 4'd15;
    a.pprot = {~prot[0], 1'b0, prot[1]};
    if (!err && !wr) model_hrdata = rdata;
    h.hrdata = model_hrdata;
    h.err    = err;
    h.waits  = 8'(err ? 3 + w : 2 + w);
    s.waits  = 8'(w);
    s.err    = err;
    s.rdata  = rdata;
    apb_q.push_back(a);
    ahb_q.push_back(h);
    slv_q.push_back(s);
    HSEL   = 1'b1;
    HTRANS = 2'b10;
    HADDR  = addr;
    HWRITE = wr;
    HSIZE  = size;
`ifdef COMMBRIDGE_APB4_EN
    HPROT  = prot;
`endif
    @(posedge PCLK); #1;
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    HWDATA = wr ? wdata : $urandom;
    wait_ready("xfer_done_timeout");
  endtask

  // ---------------- APB slave responder ----------------
  initial begin
    slv_t cur;
    int cnt;
    cur = '0;
    cnt = 0;
    forever begin
      @(posedge PCLK); #1;
      if (!PRESETn) begin
        PREADY = 1'b0;
        cnt = 0;
      end else if (PSEL && !PENABLE) begin
        if (slv_q.size() == 0) begin
          check("unexpected_apb_setup", 32'(slv_q.size()), 32'd1);
          cur = '0;
        end else begin
          cur = slv_q.pop_front();
        end
        cnt = int'(cur.waits);
        PREADY  = 1'b0;
        PSLVERR = 1'($urandom_range(0, 1));
        PRDATA  = $urandom;
      end else if (PSEL && PENABLE) begin
        if (cnt == 0) begin
          PREADY  = 1'b1;
          PSLVERR = cur.err;
          PRDATA  = cur.rdata;
        end else begin
          cnt--;
          PREADY  = 1'b0;
          PSLVERR = 1'($urandom_range(0, 1));
          PRDATA  = $urandom;
        end
      end else begin
        PREADY  = 1'($urandom_range(0, 1));
        PSLVERR = 1'b0;
        PRDATA  = $urandom;
      end
    end
  end

  // ---------------- APB monitor ----------------
  initial begin
    apb_t a;
    forever begin
      @(negedge PCLK);
      if (PRESETn) begin
        if (PENABLE) check("penable_needs_psel", 32'(PSEL), 32'd1);
        if (PSEL && PENABLE && PREADY) begin
          if (apb_q.size() == 0) begin
            check("apb_unexpected", 32'(apb_q.size()), 32'd1);
          end else begin
            a = apb_q.pop_front();
            check("apb_paddr", 32'(PADDR), 32'(a.paddr));
            check("apb_pwrite", 32'(PWRITE), 32'(a.pwrite));
            if (a.pwrite) check("apb_pwdata", PWDATA, a.pwdata);
`ifdef COMMBRIDGE_APB4_EN
            check("apb_pstrb", 32'(PSTRB), 32'(a.pstrb));
            check("apb_pprot", 32'(PPROT), 32'(a.pprot));
`endif
          end
        end
      end
    end
  end

  // ---------------- AHB monitor ----------------
  initial begin
    ahb_t h;
    logic in_data;
    int waits;
    int resp_cnt;
    in_data = 1'b0;
    waits = 0;
    resp_cnt = 0;
    forever begin
      @(negedge PCLK);
      if (!PRESETn) begin
        in_data = 1'b0;
      end else begin
        if (in_data) begin
          if (!HREADYOUT) begin
            waits++;
            if (HRESP) resp_cnt++;
          end else begin
            if (ahb_q.size() == 0) begin
              check("ahb_unexpected", 32'(ahb_q.size()), 32'd1);
            end else begin
              h = ahb_q.pop_front();
              check("ahb_wait_states", 32'(waits), 32'(h.waits));
              check("ahb_hresp", 32'(HRESP), 32'(h.err));
              check("ahb_err1_cycles", 32'(resp_cnt), h.err ? 32'd1 : 32'd0);
              check("ahb_hrdata", HRDATA, h.hrdata);
            end
            in_data = 1'b0;
          end
        end else begin
          check("idle_hreadyout", 32'(HREADYOUT), 32'd1);
          check("idle_hresp", 32'(HRESP), 32'd0);
          check("idle_psel", 32'(PSEL), 32'd0);
        end
        if (HSEL && HTRANS[1] && HREADY) begin
          in_data = 1'b1;
          waits = 0;
          resp_cnt = 0;
        end
      end
    end
  end

  // ---------------- main stimulus ----------------
  initial begin
    repeat (2) @(posedge PCLK);
    #1;
    check("rst_hreadyout", 32'(HREADYOUT), 32'd1);
    check("rst_hresp", 32'(HRESP), 32'd0);
    check("rst_hrdata", HRDATA, 32'd0);
    check("rst_psel", 32'(PSEL), 32'd0);
    check("rst_penable", 32'(PENABLE), 32'd0);
    check("rst_pwrite", 32'(PWRITE), 32'd0);
    check("rst_paddr", 32'(PADDR), 32'd0);
    check("rst_pwdata", PWDATA, 32'd0);
    PRESETn = 1'b1;
    @(posedge PCLK); #1;

    // directed cases
    issue(12'h000, 1'b1, 3'd2, 32'h0000_0041, 0, 1'b0, 32'h0);
    idle_cycles(2);
    issue(12'h004, 1'b0, 3'd2, 32'h0, 0, 1'b0, 32'h0000_0001);
    issue(12'h00C, 1'b0, 3'd2, 32'h0, 3, 1'b0, 32'hDEAD_BEEF);
    idle_cycles(1);
    issue(12'h010, 1'b1, 3'd2, 32'h1234_5678, 0, 1'b1, 32'h0);
    idle_cycles(2);
    issue(12'h008, 1'b1, 3'd2, 32'hCAFE_0008, 0, 1'b0, 32'h0);
    issue(12'h000, 1'b0, 3'd2, 32'h0, 0, 1'b0, 32'h5555_AAAA);
    issue(12'h003, 1'b1, 3'd0, 32'h0000_00AB, 1, 1'b0, 32'h0);
    issue(12'h020, 1'b0, 3'd2, 32'h0, 2, 1'b1, 32'hFFFF_0000);
    idle_cycles(1);

    // reset in the middle of an access phase
    slv_q.push_back(slv_t'{waits: 8'd20, err: 1'b0, rdata: 32'h0});
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 12'h3F4; HWRITE = 1'b1; HSIZE = 3'd2;
    @(posedge PCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'h0BAD_0BAD;
    @(posedge PCLK); #1;
    check("pre_rst_penable", 32'(PENABLE), 32'd1);
    #2;
    PRESETn = 1'b0;
    #1;
    check("midrst_psel", 32'(PSEL), 32'd0);
    check("midrst_penable", 32'(PENABLE), 32'd0);
    check("midrst_hreadyout", 32'(HREADYOUT), 32'd1);
    check("midrst_hresp", 32'(HRESP), 32'd0);
    check("midrst_hrdata", HRDATA, 32'd0);
    check("midrst_paddr", 32'(PADDR), 32'd0);
    slv_q.delete();
    apb_q.delete();
    ahb_q.delete();
    model_hrdata = '0;
    repeat (2) @(posedge PCLK);
    #1;
    PRESETn = 1'b1;
    @(posedge PCLK); #1;
    issue(12'h040, 1'b1, 3'd2, 32'h7777_0040, 0, 1'b0, 32'h0);
    issue(12'h040, 1'b0, 3'd2, 32'h0, 1, 1'b0, 32'h7777_0040);

    // randomized traffic
    for (int i = 0; i < 80; i++) begin
      issue(AW'($urandom), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 2)), $urandom,
            $urandom_range(0, 3), ($urandom_range(0, 5) == 0), $urandom);
      if ($urandom_range(0, 2) != 0) idle_cycles($urandom_range(1, 3));
    end
    idle_cycles(3);

    check("end_apb_q_empty", 32'(apb_q.size()), 32'd0);
    check("end_ahb_q_empty", 32'(ahb_q.size()), 32'd0);
    check("end_slv_q_empty", 32'(slv_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/commbridge_ahb2apb.md
Name: commbridge_ahb2apb

Overview:
- Single-clock AHB-Lite slave to APB master bridge.
- Sits directly upstream of the communications FIFO APB slave.
- Converts Cortex-M0 bus transfers into APB setup/access sequences.
- Returns read data, wait states and errors to the AHB master.

Parameters:
- ADDRWIDTH, 12: AHB address width; PADDR carries bits [ADDRWIDTH-1:2].

Ports:
- PCLK  in  1  clock, shared by AHB and APB sides
- PRESETn  in  1  asynchronous active-low reset
- HSEL  in  1  bridge select
- HADDR  in  ADDRWIDTH  AHB address
- HTRANS  in  2  transfer type; only bit 1 is used (NONSEQ/SEQ)
- HSIZE  in  3  transfer size; used only under the optional feature
- HWRITE  in  1  write flag
- HREADY  in  1  bus-level ready
- HWDATA  in  32  write data, valid in the data phase
- HREADYOUT  out  1  slave ready
- HRDATA  out  32  registered read data
- HRESP  out  1  error response
- PSEL  out  1  APB select
- PADDR  out  ADDRWIDTH-2  APB word address
- PENABLE  out  1  APB access phase
- PWRITE  out  1  APB direction
- PWDATA  out  32  APB write data
- PRDATA  in  32  APB read data
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB error

Behaviour:
- Reset (async, PRESETn=0):
  - State = IDLE.
  - HREADYOUT=1, HRESP=0, HRDATA=0.
  - PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0.
- Accept condition: HSEL & HTRANS[1] & HREADY, sampled at a rising edge.
  - On accept, register HADDR[ADDRWIDTH-1:2] -> PADDR and HWRITE -> PWRITE.
  - PADDR and PWRITE hold until the next accept.
- States:
  - IDLE: HREADYOUT=1, HRESP=0. Accept -> SETUP.
  - SETUP: PSEL=1, PENABLE=0, HREADYOUT=0.
    - PWDATA is driven combinationally from HWDATA and captured into a register at the end of SETUP.
    - Always -> ACCESS.
  - ACCESS: PSEL=1, PENABLE=1, HREADYOUT=0, PWDATA from the register.
    - PREADY=0: stay in ACCESS.
    - PREADY=1 & PSLVERR=0: capture PRDATA into HRDATA (reads only; writes leave HRDATA unchanged) -> DONE.
    - PREADY=1 & PSLVERR=1 -> ERR1.
  - DONE: PSEL=0, HREADYOUT=1, HRESP=0.
    - Accept -> SETUP; otherwise -> IDLE.
  - ERR1: PSEL=0, HREADYOUT=0, HRESP=1. Always -> ERR2.
  - ERR2: PSEL=0, HREADYOUT=1, HRESP=1.
    - Accept -> SETUP; otherwise -> IDLE.
- Latency with zero APB wait states:
  - Address phase at cycle N.
  - SETUP at N+1, ACCESS at N+2, HREADYOUT=1 at N+3 (two AHB wait states).
  - Each cycle of PREADY=0 adds one wait state.
- PSEL rules:
  - Never asserted in IDLE, DONE, ERR1 or ERR2.
  - PENABLE is only ever high while PSEL is high.
- HTRANS IDLE/BUSY (bit 1 = 0) is never accepted; HREADYOUT stays 1 and HRESP stays 0 in IDLE.
- Without the optional feature, HSIZE and HADDR[1:0] are ignored: every transfer is a full 32-bit word.
- Back-to-back transfers: an accept in DONE or ERR2 goes straight to SETUP, with no IDLE cycle between APB transfers.
- Reset mid-transfer (any state): outputs return to reset values immediately and asynchronously; the pending transfer is dropped.
- APB signals not listed for a state (PWDATA, PADDR, PWRITE) hold their last value.

Optional Feature:
- Macro: COMMBRIDGE_APB4_EN.
- Defined:
  - Adds ports PSTRB (out, 4) and PPROT (out, 3), plus HPROT (in, 4).
  - PSTRB, writes, registered on accept: byte -> 4'b0001 << HADDR[1:0]; halfword -> 4'b0011 << {HADDR[1],1'b0}; word -> 4'b1111.
  - PSTRB is 4'b0000 for reads.
  - PPROT = {~HPROT[0], 1'b0, HPROT[1]}, registered on accept.
  - Reset value of PSTRB and PPROT is 0.
- Undefined: these ports are absent; the bridge behaves exactly as specified above.

Test Plan:
- Write: HADDR=0x000, HWDATA=0x00000041, PREADY=1 -> SETUP at N+1 with PADDR=0, PWDATA=0x41; PENABLE at N+2; HREADYOUT=1 at N+3, HRESP=0.
- Read: HADDR=0x004, PRDATA=0x00000001 -> PADDR=1, PWRITE=0; HRDATA=0x00000001 when HREADYOUT rises at N+3.
- Wait states: PREADY held 0 for 3 ACCESS cycles -> HREADYOUT low 5 cycles total, HRDATA captured only on the PREADY=1 edge.
- Error: PSLVERR=1 with PREADY=1 -> ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1), then IDLE with HRESP=0.
- Back-to-back: write 0x008, then read 0x000 issued in DONE -> PSEL low only during the DONE cycle, second SETUP immediately follows; with COMMBRIDGE_APB4_EN, a byte write to 0x003 gives PSTRB=4'b1000.
- Reset: PRESETn dropped during ACCESS -> PSEL=0, PENABLE=0, HREADYOUT=1 before the next clock edge; a fresh write after release completes normally.
